store_drain_unit: RTL and testbench

- Sits directly downstream of the store queue.
- Pops one committed store at a time from the queue head, generates byte-lane data and strobes, and writes it to data memory with a req/ack handshake.
- Tracks how many retired stores are still waiting to drain, so only committed stores ever reach memory.
- Has no flush input: a pipeline flush never cancels a committed store.

---
 rtl/store_drain_unit.sv | 127 ++++++++++++
 tb/tb_store_drain_unit.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_drain_unit.sv
// Drains committed stores from the store queue head into data memory: pop at T, req at T+1.
// One outstanding write; the FSM holds the request stable until dmem_ack, so ack latency throttles pops.
module store_drain_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  commit_store_valid,
  input  logic                  sq_empty,
  input  logic [ADDR_WIDTH-1:0] sq_addr,
  input  logic [DATA_WIDTH-1:0] sq_data,
  input  logic [1:0]            sq_size,
  output logic                  store_valid,
  output logic                  dmem_req,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic [3:0]            dmem_wstrb,
  input  logic                  dmem_ack,
  output logic [CNT_WIDTH-1:0]  pending_cnt,
  output logic                  drain_idle,
  output logic                  misaligned_err,
  output logic                  overflow_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_ERR} state_e;

  state_e                state_q;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  req_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [3:0]            wstrb_q;

  logic                  pop;
  logic [DATA_WIDTH-1:0] lane_dat;
  logic [3:0]            lane_strb;
  logic                  misaligned;

  // The queue head is valid combinationally, so the pop and the latch share a cycle.
  assign pop = (state_q == ST_IDLE) && (cnt_q != '0) && !sq_empty;

  always_comb begin
    lane_dat   = sq_data;
    lane_strb  = 4'b1111;
    misaligned = (sq_addr[1:0] != 2'b00);
    case (sq_size)
      2'b00: begin
        lane_dat   = {4{sq_data[7:0]}};
        lane_strb  = 4'b0001 << sq_addr[1:0];
        misaligned = 1'b0;
      end
      2'b01: begin
        lane_dat   = {2{sq_data[15:0]}};
        lane_strb  = 4'b0011 << sq_addr[1:0];
        misaligned = sq_addr[0];
      end
      default: ;
    endcase
  end

  // A commit that would wrap the counter is dropped and flagged until reset.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (commit_store_valid && !pop) begin
      if (&cnt_q) ovf_d = 1'b1;
      else        cnt_d = cnt_q + 1'b1;
    end else if (pop && !commit_store_valid) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            if (misaligned) begin
              state_q <= ST_ERR;
              err_q   <= 1'b1;
            end else begin
              state_q <= ST_REQ;
              req_q   <= 1'b1;
              addr_q  <= {sq_addr[ADDR_WIDTH-1:2], 2'b00};
              wdata_q <= lane_dat;
              wstrb_q <= lane_strb;
            end
          end
        end
        ST_REQ: begin
          if (dmem_ack) begin
            req_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign store_valid    = pop;
  assign dmem_req       = req_q;
  assign dmem_addr      = addr_q;
  assign dmem_wdata     = wdata_q;
  assign dmem_wstrb     = wstrb_q;
  assign pending_cnt    = cnt_q;
  assign drain_idle     = (state_q == ST_IDLE) && (cnt_q == '0);
  assign misaligned_err = err_q;
  assign overflow_err   = ovf_q;

endmodule

// File: tb/tb_store_drain_unit.sv
// Scoreboard bench for store_drain_unit: a store-queue model feeds the DUT, a monitor checks every cycle.
module tb_store_drain_unit;

  localparam int CNT_MAX = 31;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
  } ent_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    bit          mis;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        commit_store_valid;
  logic        sq_empty;
  logic [31:0] sq_addr;
  logic [31:0] sq_data;
  logic [1:0]  sq_size;
  logic        store_valid;
  logic        dmem_req;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [4:0]  pending_cnt;
  logic        drain_idle;
  logic        misaligned_err;
  logic        overflow_err;

  int   n_checks = 0;
  int   n_errors = 0;
  ent_t sq[$];
  exp_t exp_q[$];
  exp_t cur;
  int   mcnt = 0;
  bit   movf = 0;
  bit   pend_q = 0;
  bit   in_req = 0;
  bit   mon_en = 0;
  bit   m_idle;
  bit   m_pop;
  int   ack_delay = 0;
  bit   spur_en = 0;
  int   wait_cnt = 0;
  int   n_push = 0;
  int   n_commit = 0;

  store_drain_unit dut (
    .clk                (clk),
    .rst                (rst),
    .commit_store_valid (commit_store_valid),
    .sq_empty           (sq_empty),
    .sq_addr            (sq_addr),
    .sq_data            (sq_data),
    .sq_size            (sq_size),
    .store_valid        (store_valid),
    .dmem_req           (dmem_req),
    .dmem_addr          (dmem_addr),
    .dmem_wdata         (dmem_wdata),
    .dmem_wstrb         (dmem_wstrb),
    .dmem_ack           (dmem_ack),
    .pending_cnt        (pending_cnt),
    .drain_idle         (drain_idle),
    .misaligned_err     (misaligned_err),
    .overflow_err       (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a store of n bytes at offset off covers lanes off..off+n-1; each lane b carries data byte b%n.
  function automatic exp_t ref_model(input ent_t e);
    exp_t r;
    int   n;
    int   off;
    n      = (e.size == 2'd0) ? 1 : (e.size == 2'd1) ? 2 : 4;
    off    = int'(e.addr[1:0]);
    r.mis  = (off % n) != 0;
    r.addr = e.addr - 32'(off);
    r.wdata = '0;
    r.wstrb = '0;
    for (int b = 0; b < 4; b++) begin
      r.wdata[8*b +: 8] = e.data[8*(b % n) +: 8];
      r.wstrb[b]        = (b >= off) && (b < off + n);
    end
    return r;
  endfunction

  task automatic refresh_head();
    sq_empty = (sq.size() == 0);
    if (sq.size() != 0) begin
      sq_addr = sq[0].addr;
      sq_data = sq[0].data;
      sq_size = sq[0].size;
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    ent_t e;
    e.addr = a;
    e.data = d;
    e.size = s;
    sq.push_back(e);
    exp_q.push_back(ref_model(e));
    n_push++;
    refresh_head();
  endtask

  task automatic push_rand();
    push($urandom() & 32'h0000_FFFF, $urandom(), 2'($urandom_range(0, 3)));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    commit_store_valid = 1'b0;
  endtask

  task automatic commit();
    commit_store_valid = 1'b1;
    n_commit++;
    tick();
  endtask

  task automatic model_clear();
    sq.delete();
    exp_q.delete();
    mcnt      = 0;
    movf      = 0;
    pend_q    = 0;
    in_req    = 0;
    ack_delay = 0;
    spur_en   = 0;
    commit_store_valid = 1'b0;
    refresh_head();
  endtask

  task automatic do_reset();
    mon_en = 0;
    rst    = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b1;
    mon_en = 1;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (!(drain_idle && !pend_q && !in_req && mcnt == 0 && sq.size() == 0) && k < 400) begin
      tick();
      k++;
    end
    chk("drain_timeout", 32'(k < 400), 32'd1);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Memory side: ack after ack_delay cycles of request, optional stray acks while idle.
  initial begin
    dmem_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (dmem_ack) begin
        dmem_ack = 1'b0;
      end else if (dmem_req) begin
        if (wait_cnt >= ack_delay) begin
          dmem_ack = 1'b1;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
        if (spur_en && $urandom_range(0, 7) == 0) dmem_ack = 1'b1;
      end
    end
  end

  // Monitor: checks outputs mid-cycle, then advances the model for the coming edge.
  always @(negedge clk) begin
    if (mon_en) begin
      m_idle = !pend_q && !in_req;
      m_pop  = m_idle && (mcnt != 0) && (sq.size() != 0);
      chk("pending_cnt", 32'(pending_cnt), 32'(mcnt));
      chk("overflow_err", 32'(overflow_err), 32'(movf));
      chk("drain_idle", 32'(drain_idle), 32'(m_idle && mcnt == 0));
      chk("store_valid", 32'(store_valid), 32'(m_pop));
      if (pend_q) begin
        if (cur.mis) begin
          chk("err_pulse", 32'(misaligned_err), 32'd1);
          chk("err_no_req", 32'(dmem_req), 32'd0);
        end else begin
          chk("req_rise", 32'(dmem_req), 32'd1);
          chk("req_addr", dmem_addr, cur.addr);
          chk("req_wdata", dmem_wdata, cur.wdata);
          chk("req_wstrb", 32'(dmem_wstrb), 32'(cur.wstrb));
          chk("req_no_err", 32'(misaligned_err), 32'd0);
          in_req = 1;
        end
        sq.delete(0);
        refresh_head();
        pend_q = 0;
      end else if (in_req) begin
        chk("req_hold", 32'(dmem_req), 32'd1);
        chk("hold_addr", dmem_addr, cur.addr);
        chk("hold_wdata", dmem_wdata, cur.wdata);
        chk("hold_wstrb", 32'(dmem_wstrb), 32'(cur.wstrb));
        chk("hold_no_err", 32'(misaligned_err), 32'd0);
      end else begin
        chk("idle_no_req", 32'(dmem_req), 32'd0);
        chk("idle_no_err", 32'(misaligned_err), 32'd0);
      end
      if (in_req && dmem_ack) in_req = 0;
      if (m_pop) begin
        cur    = exp_q.pop_front();
        pend_q = 1;
      end
      if (commit_store_valid && !m_pop) begin
        if (mcnt == CNT_MAX) movf = 1;
        else                 mcnt++;
      end else if (!commit_store_valid && m_pop) begin
        mcnt--;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1);
  end

  initial begin
    int k;
    rst = 1'b1;
    commit_store_valid = 1'b0;
    sq_addr = '0;
    sq_data = '0;
    sq_size = '0;
    sq_empty = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    chk("rst_store_valid", 32'(store_valid), 32'd0);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_wstrb", 32'(dmem_wstrb), 32'd0);
    chk("rst_cnt", 32'(pending_cnt), 32'd0);
    chk("rst_err", 32'(misaligned_err), 32'd0);
    chk("rst_ovf", 32'(overflow_err), 32'd0);
    chk("rst_idle", 32'(drain_idle), 32'd1);
    do_reset();

    // Aligned word with immediate ack.
    push(32'h100, 32'hDEADBEEF, 2'b10);
    commit();
    wait_drain();

    // Byte and halfword lane replication.
    push(32'h203, 32'h0000_00AB, 2'b00);
    push(32'h202, 32'h0000_1234, 2'b01);
    commit();
    commit();
    wait_drain();

    // Slow memory with three stores pending.
    ack_delay = 5;
    push(32'h300, 32'h1111_2222, 2'b11);
    push(32'h305, 32'h0000_0055, 2'b00);
    push(32'h30E, 32'h0000_BEEF, 2'b01);
    commit();
    commit();
    commit();
    wait_drain();
    ack_delay = 0;

    // Misaligned word is popped and dropped.
    push(32'h102, 32'hCAFEF00D, 2'b10);
    commit();
    wait_drain();

    // Uncommitted head must not drain.
    push(32'h400, 32'h0BAD_0BAD, 2'b10);
    repeat (6) tick();
    chk("uncommitted_cnt", 32'(pending_cnt), 32'd0);
    commit();
    wait_drain();

    // Commits ahead of queue writes, then commit and pop in one cycle.
    commit();
    commit();
    chk("lag_cnt", 32'(pending_cnt), 32'd2);
    push(32'h500, 32'h0000_0001, 2'b10);
    commit();
    chk("commit_pop_cnt", 32'(pending_cnt), 32'd2);
    push(32'h504, 32'h0000_0002, 2'b10);
    push(32'h508, 32'h0000_0003, 2'b10);
    wait_drain();

    // Randomized traffic with varying ack latency and stray acks.
    n_push   = 0;
    n_commit = 0;
    spur_en  = 1;
    for (int i = 0; i < 1500; i++) begin
      if (sq.size() < 16 && $urandom_range(0, 2) == 0) push_rand();
      if ($urandom_range(0, 15) == 0) ack_delay = $urandom_range(0, 4);
      if (n_commit < n_push + 2 && mcnt < 28 && $urandom_range(0, 1) == 0) begin
        commit_store_valid = 1'b1;
        n_commit++;
      end
      tick();
    end
    while (n_push < n_commit) begin
      push_rand();
      tick();
    end
    while (n_commit < n_push) commit();
    wait_drain();
    spur_en   = 0;
    ack_delay = 0;

    // Counter saturation.
    do_reset();
    for (int i = 0; i < 31; i++) commit();
    chk("sat_cnt", 32'(pending_cnt), 32'd31);
    chk("sat_no_ovf", 32'(overflow_err), 32'd0);
    commit();
    chk("ovf_cnt", 32'(pending_cnt), 32'd31);
    chk("ovf_set", 32'(overflow_err), 32'd1);
    repeat (3) tick();
    chk("ovf_sticky", 32'(overflow_err), 32'd1);

    // Reset while a write is outstanding.
    do_reset();
    ack_delay = 20;
    push(32'h600, 32'h7777_8888, 2'b10);
    commit();
    k = 0;
    while (!dmem_req && k < 20) begin
      tick();
      k++;
    end
    chk("req_before_reset", 32'(dmem_req), 32'd1);
    mon_en = 0;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_req", 32'(dmem_req), 32'd0);
    chk("arst_store_valid", 32'(store_valid), 32'd0);
    chk("arst_addr", dmem_addr, 32'd0);
    chk("arst_wdata", dmem_wdata, 32'd0);
    chk("arst_wstrb", 32'(dmem_wstrb), 32'd0);
    chk("arst_cnt", 32'(pending_cnt), 32'd0);
    chk("arst_err", 32'(misaligned_err), 32'd0);
    chk("arst_ovf", 32'(overflow_err), 32'd0);
    model_clear();
    @(posedge clk);
    #1;
    rst    = 1'b1;
    mon_en = 1;
    push(32'h700, 32'h0000_00C3, 2'b00);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_reset_no_req", 32'(dmem_req), 32'd0);
    end
    commit();
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
